// File: rtl/cpu_param.sv
// Multi-cycle 8-register CPU with a parameterised datapath and a fixed 16-bit instruction word.
// Define CPU_ILLEGAL_TRAP_EN to trap on illegal encodings; otherwise they execute as NOP.
module cpu_param #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              err
);

  typedef enum logic [2:0] {
    WAIT, DECODE, GETA, GETB, EXEC, WRITEREG, WRITEIMM, TRAP
  } state_t;

  state_t state, next_state;

  logic [15:0]              ir;
  logic [15:0]              instr;
  logic signed [DATA_W-1:0] regs [8];
  logic signed [DATA_W-1:0] a_reg, b_reg;
  logic signed [DATA_W-1:0] shifted, alu, diff, imm_ext;
  logic signed [7:0]        imm8;
  logic [2:0]               opc, rn, rd, rm;
  logic [1:0]               op, sh;
  logic                     is_movi, is_movr, is_alu, is_cmp, is_mvn;

  function automatic logic signed [DATA_W-1:0] shift_op(
    input logic signed [DATA_W-1:0] x,
    input logic [1:0]               amt
  );
    case (amt)
      2'b01:   shift_op = x <<< 1;
      2'b10:   shift_op = $signed($unsigned(x) >> 1);
      2'b11:   shift_op = x >>> 1;
      default: shift_op = x;
    endcase
  endfunction

  function automatic logic sub_ovf(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y,
    input logic signed [DATA_W-1:0] d
  );
    sub_ovf = (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
  endfunction

  // Decode works from the snapshot so IR can be reloaded mid-instruction
  assign opc     = instr[15:13];
  assign op      = instr[12:11];
  assign rn      = instr[10:8];
  assign rd      = instr[7:5];
  assign sh      = instr[4:3];
  assign rm      = instr[2:0];
  assign imm8    = instr[7:0];
  assign imm_ext = DATA_W'(imm8);

  assign is_movi = (opc == 3'b110) && (op == 2'b10);
  assign is_movr = (opc == 3'b110) && (op == 2'b00);
  assign is_alu  = (opc == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);

  assign shifted = shift_op(b_reg, sh);
  assign diff    = a_reg - shifted;

  always_comb begin
    alu = shifted;
    if (is_alu) begin
      case (op)
        2'b00:   alu = a_reg + shifted;
        2'b01:   alu = diff;
        2'b10:   alu = a_reg & shifted;
        default: alu = ~shifted;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT:     if (s) next_state = DECODE;
      DECODE: begin
        if (is_movi)                  next_state = WRITEIMM;
        else if (is_movr || is_mvn)   next_state = GETB;
        else if (is_alu)              next_state = GETA;
        else
`ifdef CPU_ILLEGAL_TRAP_EN
                                      next_state = TRAP;
`else
                                      next_state = WAIT;
`endif
      end
      GETA:     next_state = GETB;
      GETB:     next_state = EXEC;
      EXEC:     next_state = is_cmp ? WAIT : WRITEREG;
      WRITEREG: next_state = WAIT;
      WRITEIMM: next_state = WAIT;
      TRAP:     next_state = TRAP;
      default:  next_state = WAIT;
    endcase
  end

  always_comb begin
    w = (state == WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir  <= '0;
      out <= '0;
      N   <= 1'b0;
      V   <= 1'b0;
      Z   <= 1'b0;
    end else begin
      if (load) ir <= in;
      if (state == EXEC) begin
        out <= $unsigned(alu);
        if (is_cmp) begin
          N <= diff[DATA_W-1];
          Z <= (diff == '0);
          V <= sub_ovf(a_reg, shifted, diff);
        end
      end
    end
  end

  // Register file and operand latches carry no reset; writes are blocked on a reset edge
  always_ff @(posedge clk) begin
    if (state == WAIT && s) instr <= ir;
    if (state == GETA)      a_reg <= regs[rn];
    if (state == GETB)      b_reg <= regs[rm];
    if (!reset && state == WRITEREG) regs[rd] <= $signed(out);
    if (!reset && state == WRITEIMM) regs[rn] <= imm_ext;
  end

`ifdef CPU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                                              err <= 1'b0;
    else if (state == DECODE && !(is_movi || is_movr || is_alu)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: directed cases plus random programs against an arithmetic model.
module tb_cpu_param;
  localparam int    W    = 16;
  localparam longint HALF = longint'(1) << (W - 1);
  localparam longint MASK = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, s, load;
  logic [15:0]   in;
  logic [W-1:0]  out;
  logic          N, V, Z, w, err;
  logic          s32, load32;
  logic [15:0]   in32;
  logic [31:0]   out32;
  logic          N32, V32, Z32, w32, err32;

  cpu_param #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .out(out),
    .N(N), .V(V), .Z(Z), .w(w), .err(err)
  );

  cpu_param #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .s(s32), .load(load32), .in(in32), .out(out32),
    .N(N32), .V(V32), .Z(Z32), .w(w32), .err(err32)
  );

  int total = 0;
  int bad   = 0;

  longint mr [8];
  longint mout;
  logic   mN, mV, mZ;

  function automatic logic [15:0] enc_imm(input logic [2:0] rn, input logic [7:0] imm);
    return {3'b110, 2'b10, rn, imm};
  endfunction

  function automatic logic [15:0] enc_op(input logic [2:0] opc, input logic [1:0] op,
                                         input logic [2:0] rn, input logic [2:0] rd,
                                         input logic [1:0] sh, input logic [2:0] rm);
    return {opc, op, rn, rd, sh, rm};
  endfunction

  function automatic longint sgn(input longint x);
    return (x >= HALF) ? x - (MASK + 1) : x;
  endfunction

  function automatic longint shf(input longint x, input logic [1:0] sh);
    longint sv;
    case (sh)
      2'd1: return (x * 2) & MASK;
      2'd2: return x / 2;
      2'd3: begin
        sv = sgn(x);
        sv = (sv < 0) ? (sv - 1) / 2 : sv / 2;
        return sv & MASK;
      end
      default: return x;
    endcase
  endfunction

  // Architectural effect of one instruction and edges from start until w returns
  task automatic model_exec(input logic [15:0] i, output int lat);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    longint a, b, r, d;
    opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
    if (opc == 3'b110 && op == 2'b10) begin
      r = longint'(i[7:0]);
      if (r >= 128) r = r - 256;
      mr[rn] = r & MASK;
      lat = 2;
    end else if (opc == 3'b110 && op == 2'b00) begin
      r = shf(mr[rm], sh);
      mout = r; mr[rd] = r; lat = 4;
    end else if (opc == 3'b101) begin
      a = mr[rn];
      b = shf(mr[rm], sh);
      case (op)
        2'd0: begin r = (a + b) & MASK; mout = r; mr[rd] = r; lat = 5; end
        2'd1: begin
          d = sgn(a) - sgn(b);
          r = d & MASK;
          mout = r; mN = (r >= HALF); mZ = (r == 0);
          mV = (d >= HALF) || (d < -HALF);
          lat = 4;
        end
        2'd2: begin r = a & b; mout = r; mr[rd] = r; lat = 5; end
        default: begin r = (~b) & MASK; mout = r; mr[rd] = r; lat = 4; end
      endcase
    end else begin
      lat = 1;
    end
  endtask

  task automatic model_reset();
    mout = 0; mN = 1'b0; mV = 1'b0; mZ = 1'b0;
  endtask

  task automatic run(input logic [15:0] i, output int e);
    @(negedge clk); in = i; load = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b1;
    @(negedge clk); s = 1'b0; e = 0;
    while (!w && e < 20) begin @(negedge clk); e++; end
  endtask

  task automatic run32(input logic [15:0] i, output int e);
    @(negedge clk); in32 = i; load32 = 1'b1;
    @(negedge clk); load32 = 1'b0; s32 = 1'b1;
    @(negedge clk); s32 = 1'b0; e = 0;
    while (!w32 && e < 20) begin @(negedge clk); e++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++; if ({N, V, Z} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {N, V, Z}); end
    total++; if (w !== 1'b1) begin bad++; $display("FAIL reset_w got=%b want=1", w); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (w32 !== 1'b1 || out32 !== '0) begin bad++; $display("FAIL reset_32 w=%b out=%h want w=1 out=0", w32, out32); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_mov_shift();
    int e, lat;
    logic [15:0] i;
    i = enc_imm(3'd0, 8'd10); model_exec(i, lat); run(i, e);
    total++; if (e !== 2) begin bad++; $display("FAIL movimm_lat got=%0d want=2", e); end
    i = enc_op(3'b110, 2'b00, 3'd0, 3'd1, 2'd1, 3'd0); model_exec(i, lat); run(i, e);
    total++; if (out !== 16'd20) begin bad++; $display("FAIL mov_lsl out=%h want=%h", out, 16'd20); end
    total++; if (e !== 4) begin bad++; $display("FAIL mov_lsl_lat got=%0d want=4", e); end
    i = enc_imm(3'd5, 8'hE2); model_exec(i, lat); run(i, e);
    total++; if (out !== 16'd20) begin bad++; $display("FAIL movimm_keeps_out out=%h want=%h", out, 16'd20); end
    i = enc_op(3'b110, 2'b00, 3'd0, 3'd6, 2'd3, 3'd5); model_exec(i, lat); run(i, e);
    total++; if (out !== 16'hFFF1) begin bad++; $display("FAIL mov_asr out=%h want=fff1", out); end
    i = enc_op(3'b110, 2'b00, 3'd0, 3'd6, 2'd2, 3'd5); model_exec(i, lat); run(i, e);
    total++; if (out !== 16'h7FF1) begin bad++; $display("FAIL mov_lsr out=%h want=7ff1", out); end
  endtask

  task automatic test_add_cmp();
    int e, lat;
    logic [15:0] i;
    i = enc_imm(3'd5, 8'd4); model_exec(i, lat); run(i, e);
    i = enc_op(3'b101, 2'b00, 3'd1, 3'd2, 2'd0, 3'd5); model_exec(i, lat); run(i, e);
    total++; if (out !== 16'd24) begin bad++; $display("FAIL add out=%h want=%h", out, 16'd24); end
    total++; if (e !== 5) begin bad++; $display("FAIL add_lat got=%0d want=5", e); end
    i = enc_op(3'b101, 2'b01, 3'd2, 3'd0, 2'd0, 3'd2); model_exec(i, lat); run(i, e);
    total++; if ({N, V, Z} !== 3'b001) begin bad++; $display("FAIL cmp_eq NVZ=%b want=001", {N, V, Z}); end
    total++; if (e !== 4) begin bad++; $display("FAIL cmp_lat got=%0d want=4", e); end
  endtask

  task automatic test_overflow();
    int e, lat;
    logic [15:0] i;
    i = enc_imm(3'd0, 8'hFF); model_exec(i, lat); run(i, e);
    i = enc_op(3'b110, 2'b00, 3'd0, 3'd0, 2'd2, 3'd0); model_exec(i, lat); run(i, e);
    total++; if (out !== 16'h7FFF) begin bad++; $display("FAIL r0_setup out=%h want=7fff", out); end
    i = enc_imm(3'd1, 8'hFF); model_exec(i, lat); run(i, e);
    i = enc_op(3'b101, 2'b01, 3'd0, 3'd0, 2'd0, 3'd1); model_exec(i, lat); run(i, e);
    total++; if ({N, V, Z} !== 3'b110) begin bad++; $display("FAIL cmp_ovf NVZ=%b want=110", {N, V, Z}); end
    total++; if (out !== 16'h8000) begin bad++; $display("FAIL cmp_ovf_out out=%h want=8000", out); end
  endtask

  task automatic test_reset_mid();
    int e, lat;
    logic [15:0] i;
    i = enc_op(3'b101, 2'b00, 3'd1, 3'd2, 2'd0, 3'd5);
    @(negedge clk); in = i; load = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b1;
    @(negedge clk); s = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (w !== 1'b1) begin bad++; $display("FAIL midreset_w got=%b want=1", w); end
    total++; if (out !== '0 || {N, V, Z} !== 3'b000) begin bad++; $display("FAIL midreset_state out=%h NVZ=%b want 0/000", out, {N, V, Z}); end
    reset = 1'b0;
    model_reset();
    i = enc_op(3'b110, 2'b00, 3'd0, 3'd3, 2'd0, 3'd2); model_exec(i, lat); run(i, e);
    total++; if (out !== mout[W-1:0]) begin bad++; $display("FAIL midreset_rd_kept out=%h want=%h", out, mout[W-1:0]); end
  endtask

  task automatic test_illegal();
    int e, lat;
    logic [15:0] i;
    i = enc_imm(3'd4, 8'd77); model_exec(i, lat); run(i, e);
    @(negedge clk); reset = 1'b1; load = 1'b1; in = enc_imm(3'd4, 8'd5); s = 1'b1;
    @(negedge clk); reset = 1'b0; load = 1'b0; s = 1'b0;
    model_reset();
    total++; if (w !== 1'b1) begin bad++; $display("FAIL reset_over_s w=%b want=1", w); end
`ifdef CPU_ILLEGAL_TRAP_EN
    @(negedge clk); s = 1'b1;
    @(negedge clk); s = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1 || w !== 1'b0) begin bad++; $display("FAIL trap err=%b w=%b want 1/0", err, w); end
    s = 1'b1; repeat (3) @(negedge clk); s = 1'b0;
    total++; if (w !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL trap_held err=%b w=%b want 1/0", err, w); end
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    total++; if (err !== 1'b0 || w !== 1'b1) begin bad++; $display("FAIL trap_clear err=%b w=%b want 0/1", err, w); end
`else
    run(16'h0000, e);
    total++; if (e !== 1) begin bad++; $display("FAIL nop_lat got=%0d want=1", e); end
    total++; if (err !== 1'b0 || out !== '0) begin bad++; $display("FAIL nop_state err=%b out=%h want 0/0", err, out); end
`endif
    i = enc_op(3'b110, 2'b00, 3'd0, 3'd3, 2'd0, 3'd4); model_exec(i, lat); run(i, e);
    total++; if (out !== 16'd77) begin bad++; $display("FAIL reset_over_load out=%h want=%h", out, 16'd77); end
  endtask

  task automatic test_back_to_back();
    int n, la, lb;
    logic [15:0] ia, ib;
    ia = enc_op(3'b110, 2'b00, 3'd0, 3'd7, 2'd0, 3'd2);
    ib = enc_op(3'b101, 2'b00, 3'd7, 3'd7, 2'd0, 3'd5);
    @(negedge clk); in = ia; load = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b1;
    @(negedge clk); in = ib; load = 1'b1;
    @(negedge clk); load = 1'b0; n = 1;
    while (!w && n < 20) begin @(negedge clk); n++; end
    model_exec(ia, la);
    total++; if (n !== la || out !== mout[W-1:0]) begin bad++; $display("FAIL b2b_first edges=%0d out=%h want %0d/%h", n, out, la, mout[W-1:0]); end
    @(negedge clk); s = 1'b0; n = 0;
    total++; if (w !== 1'b0) begin bad++; $display("FAIL b2b_restart w=%b want=0", w); end
    while (!w && n < 20) begin @(negedge clk); n++; end
    model_exec(ib, lb);
    total++; if (n !== lb || out !== mout[W-1:0]) begin bad++; $display("FAIL b2b_second edges=%0d out=%h want %0d/%h", n, out, lb, mout[W-1:0]); end
  endtask

  task automatic test_random();
    int e, lat, k;
    logic [15:0] i;
    for (int r = 0; r < 8; r++) begin
      i = enc_imm(3'(r), 8'($urandom_range(0, 255))); model_exec(i, lat); run(i, e);
    end
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: i = enc_imm(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        1: i = enc_op(3'b110, 2'b00, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        default: i = enc_op(3'b101, 2'(k - 2), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      endcase
      model_exec(i, lat); run(i, e);
      total++; if (e !== lat) begin bad++; $display("FAIL rand_lat[%0d] instr=%h got=%0d want=%0d", t, i, e, lat); end
      total++; if (out !== mout[W-1:0]) begin bad++; $display("FAIL rand_out[%0d] instr=%h got=%h want=%h", t, i, out, mout[W-1:0]); end
      total++; if ({N, V, Z} !== {mN, mV, mZ}) begin bad++; $display("FAIL rand_flags[%0d] instr=%h got=%b want=%b", t, i, {N, V, Z}, {mN, mV, mZ}); end
    end
  endtask

  task automatic test_width32();
    int e;
    run32(enc_imm(3'd3, 8'hFF), e);
    total++; if (e !== 2) begin bad++; $display("FAIL w32_movimm_lat got=%0d want=2", e); end
    run32(enc_op(3'b110, 2'b00, 3'd0, 3'd4, 2'd0, 3'd3), e);
    total++; if (out32 !== 32'hFFFFFFFF) begin bad++; $display("FAIL w32_mov out=%h want=ffffffff", out32); end
    run32(enc_op(3'b110, 2'b00, 3'd0, 3'd4, 2'd2, 3'd3), e);
    total++; if (out32 !== 32'h7FFFFFFF) begin bad++; $display("FAIL w32_lsr out=%h want=7fffffff", out32); end
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = '0;
    s32 = 1'b0; load32 = 1'b0; in32 = '0;
    for (int r = 0; r < 8; r++) mr[r] = 0;
    model_reset();
    test_reset();
    test_mov_shift();
    test_add_cmp();
    test_overflow();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    test_random();
    test_width32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
